id_exe_reg: RTL

- ID/EXE pipeline register, sitting directly downstream of the decode-stage control unit and the register-file read.
- Latches the decoded control bundle (exe_cmd, MEM_R_EN, MEM_W_EN, WB_EN, B, S) and the operand/data fields once per cycle and presents them to the execute stage.
- Supports three controls:
  - freeze: hold contents, for a load-use hazard stall.
  - flush: insert a bubble when a branch is taken in EXE.
  - valid tracking: lets downstream stages tell a real instruction from a bubble.

---
 rtl/id_exe_reg.sv | 102 ++++++++++
 1 files changed

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with freeze, flush and valid tracking; ID_EXE_FORWARDING_EN adds src1/src2 registers
module id_exe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  valid_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  wb_en_in,
  input  logic                  b_in,
  input  logic                  s_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [11:0]           shift_operand_in,
  input  logic [23:0]           signed_imm_24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  carry_in,
  input  logic [REG_ADDR_W-1:0] src1_in,
  input  logic [REG_ADDR_W-1:0] src2_in,
  output logic                  valid_out,
  output logic [3:0]            exe_cmd_out,
  output logic                  mem_r_en_out,
  output logic                  mem_w_en_out,
  output logic                  wb_en_out,
  output logic                  b_out,
  output logic                  s_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic                  imm_out,
  output logic [11:0]           shift_operand_out,
  output logic [23:0]           signed_imm_24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  carry_out,
  output logic [REG_ADDR_W-1:0] src1_out,
  output logic [REG_ADDR_W-1:0] src2_out
);

  // Main bundle: reset, then flush (bubble, beats freeze), then freeze (hold), else load
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      valid_out         <= 1'b0;
      exe_cmd_out       <= '0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      wb_en_out         <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      dest_out          <= '0;
      carry_out         <= 1'b0;
    end else if (!freeze) begin
      valid_out         <= valid_in;
      exe_cmd_out       <= exe_cmd_in;
      mem_r_en_out      <= mem_r_en_in;
      mem_w_en_out      <= mem_w_en_in;
      wb_en_out         <= wb_en_in;
      b_out             <= b_in;
      s_out             <= s_in;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      dest_out          <= dest_in;
      carry_out         <= carry_in;
    end
  end

`ifdef ID_EXE_FORWARDING_EN
  // Forwarding indices follow exactly the same reset/flush/freeze rules as the bundle
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      src1_out <= '0;
      src2_out <= '0;
    end else if (!freeze) begin
      src1_out <= src1_in;
      src2_out <= src2_in;
    end
  end
`else
  // Without forwarding the EXE stage never looks at the source indices
  logic unused_src;
  assign unused_src = ^{src1_in, src2_in};
  assign src1_out   = '0;
  assign src2_out   = '0;
`endif

endmodule
